// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the L1-to-memory bus arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDRW = 64;
    localparam int unsigned TAGW  = 13;
    localparam int unsigned BLKW  = 512;
    localparam int unsigned NREQ  = 2;

    // Tag bit 0 carries the read/write flag; upper bits are type and id.
    localparam int unsigned TAG_RW_BIT = 0;
    localparam logic        TAG_READ   = 1'b1;
    localparam logic        TAG_WRITE  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETURN
    } arb_state_e;

    // Request payload latched from the granted requester onto the memory bus.
    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [TAGW-1:0]  tag;
        logic [BLKW-1:0]  data;
    } mem_req_t;

endpackage

// File: rtl/mod_mem_arbiter_picker.sv
// Two-input grant selector. Round-robin against last_grant by default;
// with ARB_DCACHE_PRIO_EN defined the dcache (index 1) always wins a tie.
module mod_rr_picker
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            last_grant_i,
    output logic            grant_c_o,
    output logic            valid_c_o
);

`ifdef ARB_DCACHE_PRIO_EN
    // Fixed priority makes the round-robin history irrelevant.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    // Grant index: a lone requester wins outright; a tie is resolved here.
    always_comb begin
        valid_c_o = |req_i;
        grant_c_o = req_i[1];
`ifndef ARB_DCACHE_PRIO_EN
        if (&req_i) begin
            grant_c_o = ~last_grant_i;
        end
`endif
    end

endmodule

// File: rtl/mod_mem_arbiter.sv
// Arbiter sharing one memory bus between the L1 icache (0) and dcache (1).
// One outstanding memory transaction; the response returns to its issuer.
// Build option: ARB_DCACHE_PRIO_EN selects fixed dcache priority on a tie.
module mod_mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0][ADDRW-1:0]  up_req,
    input  logic [NREQ-1:0][TAGW-1:0]   up_reqtag,
    input  logic [NREQ-1:0][BLKW-1:0]   up_reqdata,
    input  logic [NREQ-1:0]             up_reqcyc,
    output logic [NREQ-1:0]             up_reqack,
    output logic [BLKW-1:0]             up_resp,
    output logic [TAGW-1:0]             up_resptag,
    output logic [NREQ-1:0]             up_respcyc,
    input  logic [NREQ-1:0]             up_respack,
    output logic [ADDRW-1:0]            mem_req,
    output logic [TAGW-1:0]             mem_reqtag,
    output logic [BLKW-1:0]             mem_reqdata,
    output logic                        mem_reqcyc,
    input  logic                        mem_reqack,
    input  logic [BLKW-1:0]             mem_resp,
    input  logic [TAGW-1:0]             mem_resptag,
    input  logic                        mem_respcyc,
    output logic                        mem_respack
);

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    mem_req_t         mreq_q, mreq_d;
    logic             mem_reqcyc_q, mem_reqcyc_d;
    logic [NREQ-1:0]  up_reqack_q, up_reqack_d;
    logic [NREQ-1:0]  up_respcyc_q, up_respcyc_d;
    logic [BLKW-1:0]  up_resp_q, up_resp_d;
    logic [TAGW-1:0]  up_resptag_q, up_resptag_d;

    logic             pick_grant_c;
    logic             pick_valid_c;

    mod_rr_picker u_picker (
        .req_i        (up_reqcyc),
        .last_grant_i (last_grant_q),
        .grant_c_o    (pick_grant_c),
        .valid_c_o    (pick_valid_c)
    );

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mreq_q       <= '0;
            mem_reqcyc_q <= 1'b0;
            up_reqack_q  <= '0;
            up_respcyc_q <= '0;
            up_resp_q    <= '0;
            up_resptag_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mreq_q       <= mreq_d;
            mem_reqcyc_q <= mem_reqcyc_d;
            up_reqack_q  <= up_reqack_d;
            up_respcyc_q <= up_respcyc_d;
            up_resp_q    <= up_resp_d;
            up_resptag_q <= up_resptag_d;
        end
    end

    // Next-state and output decode for the grant/issue/wait/return cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mreq_d       = mreq_q;
        mem_reqcyc_d = mem_reqcyc_q;
        up_reqack_d  = '0;
        up_respcyc_d = up_respcyc_q;
        up_resp_d    = up_resp_q;
        up_resptag_d = up_resptag_q;
        mem_respack  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    grant_d                   = pick_grant_c;
                    mreq_d.addr               = up_req[pick_grant_c];
                    mreq_d.tag                = up_reqtag[pick_grant_c];
                    mreq_d.data               = up_reqdata[pick_grant_c];
                    up_reqack_d[pick_grant_c] = 1'b1;
                    mem_reqcyc_d              = 1'b1;
                    state_d                   = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_reqack) begin
                    mem_reqcyc_d = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // Only here is a memory response accepted; elsewhere it is ignored.
                mem_respack = mem_respcyc;
                if (mem_respcyc) begin
                    up_resp_d             = mem_resp;
                    up_resptag_d          = mem_resptag;
                    up_respcyc_d[grant_q] = 1'b1;
                    state_d               = RETURN;
                end
            end
            RETURN: begin
                if (up_respack[grant_q]) begin
                    up_respcyc_d = '0;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign up_reqack   = up_reqack_q;
    assign up_respcyc  = up_respcyc_q;
    assign up_resp     = up_resp_q;
    assign up_resptag  = up_resptag_q;
    assign mem_req     = mreq_q.addr;
    assign mem_reqtag  = mreq_q.tag;
    assign mem_reqdata = mreq_q.data;
    assign mem_reqcyc  = mem_reqcyc_q;

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Self-checking bench for mod_mem_arbiter: scoreboard of expected responses,
// a bench-side memory responder, and directed scenarios.
module tb_mod_mem_arbiter;
    import mem_arb_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NREQ-1:0][ADDRW-1:0]  up_req;
    logic [NREQ-1:0][TAGW-1:0]   up_reqtag;
    logic [NREQ-1:0][BLKW-1:0]   up_reqdata;
    logic [NREQ-1:0]             up_reqcyc;
    logic [NREQ-1:0]             up_reqack;
    logic [BLKW-1:0]             up_resp;
    logic [TAGW-1:0]             up_resptag;
    logic [NREQ-1:0]             up_respcyc;
    logic [NREQ-1:0]             up_respack;
    logic [ADDRW-1:0]            mem_req;
    logic [TAGW-1:0]             mem_reqtag;
    logic [BLKW-1:0]             mem_reqdata;
    logic                        mem_reqcyc;
    logic                        mem_reqack;
    logic [BLKW-1:0]             mem_resp;
    logic [TAGW-1:0]             mem_resptag;
    logic                        mem_respcyc;
    logic                        mem_respack;

    mod_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .up_req      (up_req),
        .up_reqtag   (up_reqtag),
        .up_reqdata  (up_reqdata),
        .up_reqcyc   (up_reqcyc),
        .up_reqack   (up_reqack),
        .up_resp     (up_resp),
        .up_resptag  (up_resptag),
        .up_respcyc  (up_respcyc),
        .up_respack  (up_respack),
        .mem_req     (mem_req),
        .mem_reqtag  (mem_reqtag),
        .mem_reqdata (mem_reqdata),
        .mem_reqcyc  (mem_reqcyc),
        .mem_reqack  (mem_reqack),
        .mem_resp    (mem_resp),
        .mem_resptag (mem_resptag),
        .mem_respcyc (mem_respcyc),
        .mem_respack (mem_respack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              who;
        logic [BLKW-1:0] data;
        logic [TAGW-1:0] tag;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ack_cnt[2] = '{0, 0};
    logic hold_req = 1'b0;

    task automatic chk(input string tag, input logic [BLKW-1:0] got, input logic [BLKW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLKW-1:0] exp_data(input logic [ADDRW-1:0] a, input logic [7:0] f);
        return {8{a}} ^ {64{f}};
    endfunction

    task automatic set_req(input int i, input logic [ADDRW-1:0] a, input logic [TAGW-1:0] t,
                           input logic [BLKW-1:0] d);
        up_req[i]     = a;
        up_reqtag[i]  = t;
        up_reqdata[i] = d;
        up_reqcyc[i]  = 1'b1;
    endtask

    task automatic push_exp(input int who, input logic [ADDRW-1:0] a, input logic [7:0] f,
                            input logic [TAGW-1:0] t);
        sb_t e;
        e.who  = who;
        e.data = exp_data(a, f);
        e.tag  = t;
        sb_q.push_back(e);
    endtask

    // Memory side of one transaction: accept after ack_dly cycles, answer
    // resp_dly cycles later with data derived from the captured address.
    task automatic serve_mem(input int ack_dly, input int resp_dly, input logic [7:0] fill,
                             output int g, output logic [ADDRW-1:0] a,
                             output logic [TAGW-1:0] t, output logic [BLKW-1:0] d);
        int n;
        g = -1;
        a = '0;
        t = '0;
        d = '0;
        n = 0;
        while (!mem_reqcyc && n < 50) begin
            tick();
            n++;
        end
        chk("mem_reqcyc_seen", mem_reqcyc, 1);
        if (!mem_reqcyc) return;
        g = up_reqack[1] ? 1 : 0;
        if (!hold_req) up_reqcyc = up_reqcyc & ~up_reqack;
        a = mem_req;
        t = mem_reqtag;
        d = mem_reqdata;
        repeat (ack_dly) tick();
        chk("mem_reqcyc_held", mem_reqcyc, 1);
        chk("mem_req_stable", mem_req, a);
        chk("mem_reqdata_stable", mem_reqdata, d);
        mem_reqack = 1'b1;
        tick();
        mem_reqack = 1'b0;
        chk("mem_reqcyc_drop", mem_reqcyc, 0);
        repeat (resp_dly) tick();
        mem_resp    = exp_data(a, fill);
        mem_resptag = t;
        mem_respcyc = 1'b1;
        #1;
        n = 0;
        while (!mem_respack && n < 50) begin
            tick();
            n++;
        end
        chk("mem_respack_seen", mem_respack, 1);
        tick();
        mem_respcyc = 1'b0;
        mem_resp    = '0;
        mem_resptag = '0;
    endtask

    // Monitor: one-hot checks and scoreboard pop on each upstream response handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (up_reqack != '0) begin
                chk("reqack_onehot", $onehot(up_reqack), 1);
                for (int i = 0; i < 2; i++) if (up_reqack[i]) ack_cnt[i]++;
            end
            if ((up_respcyc & up_respack) != '0) begin
                chk("respcyc_onehot", $onehot(up_respcyc), 1);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_resp", up_respcyc, '0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_who", up_respcyc[1] ? 1 : 0, mon_e.who);
                    chk("resp_data", up_resp, mon_e.data);
                    chk("resp_tag", up_resptag, mon_e.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int               g, a0, a1, n;
        int               ord[4];
        int               cnt[2];
        logic [ADDRW-1:0] ma;
        logic [TAGW-1:0]  mt;
        logic [BLKW-1:0]  md;

        reset       = 1'b1;
        up_req      = '0;
        up_reqtag   = '0;
        up_reqdata  = '0;
        up_reqcyc   = '0;
        up_respack  = 2'b11;
        mem_reqack  = 1'b0;
        mem_resp    = '0;
        mem_resptag = '0;
        mem_respcyc = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_up_reqack", up_reqack, 0);
        chk("rst_up_respcyc", up_respcyc, 0);
        chk("rst_mem_reqcyc", mem_reqcyc, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_reqtag", mem_reqtag, 0);
        chk("rst_mem_reqdata", mem_reqdata, 0);
        chk("rst_up_resp", up_resp, 0);
        chk("rst_up_resptag", up_resptag, 0);
        chk("rst_mem_respack", mem_respack, 0);
        reset = 1'b0;
        tick();

        // Spurious memory response while idle
        mem_respcyc = 1'b1;
        mem_resp    = {64{8'hEE}};
        repeat (3) begin
            tick();
            chk("spur_respack", mem_respack, 0);
            chk("spur_respcyc", up_respcyc, 0);
        end
        mem_respcyc = 1'b0;
        mem_resp    = '0;
        tick();

        // Single icache read
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        set_req(0, 64'h1000, 13'h001, '0);
        push_exp(0, 64'h1000, 8'hAA, 13'h001);
        serve_mem(2, 3, 8'hAA, g, ma, mt, md);
        chk("ic_grant", g, 0);
        chk("ic_mem_req", ma, 64'h1000);
        chk("ic_mem_reqtag", mt, 13'h001);
        repeat (3) tick();
        chk("ic_ack_cnt0", ack_cnt[0] - a0, 1);
        chk("ic_ack_cnt1", ack_cnt[1] - a1, 0);

        // Dcache write
        set_req(1, 64'h4040, {12'h000, TAG_WRITE}, {64{8'h55}});
        push_exp(1, 64'h4040, 8'h3C, {12'h000, TAG_WRITE});
        serve_mem(3, 2, 8'h3C, g, ma, mt, md);
        chk("wr_grant", g, 1);
        chk("wr_mem_req", ma, 64'h4040);
        chk("wr_mem_rw_bit", mt[TAG_RW_BIT], TAG_WRITE);
        chk("wr_mem_reqdata", md, {64{8'h55}});
        repeat (3) tick();

        // Simultaneous requests, both held for two transactions each
`ifdef ARB_DCACHE_PRIO_EN
        ord = '{1, 1, 0, 0};
`else
        ord = '{0, 1, 0, 1};
`endif
        hold_req = 1'b1;
        cnt      = '{0, 0};
        set_req(0, 64'h2000, {12'h008, TAG_READ}, '0);
        set_req(1, 64'h3000, {12'h009, TAG_READ}, '0);
        for (int k = 0; k < 4; k++) begin
            push_exp(ord[k], (ord[k] == 1) ? 64'h3000 : 64'h2000, 8'h10 + 8'(k),
                     (ord[k] == 1) ? {12'h009, TAG_READ} : {12'h008, TAG_READ});
        end
        for (int k = 0; k < 4; k++) begin
            serve_mem((k % 2 == 0) ? 0 : 1, 1, 8'h10 + 8'(k), g, ma, mt, md);
            chk("sim_grant", g, ord[k]);
            chk("sim_mem_req", ma, (ord[k] == 1) ? 64'h3000 : 64'h2000);
            if (g == 0 || g == 1) begin
                cnt[g]++;
                if (cnt[g] == 2) up_reqcyc[g] = 1'b0;
            end
        end
        hold_req = 1'b0;
        repeat (3) tick();

        // Slow respack with icache request pending
        up_respack = '0;
        set_req(1, 64'h5000, {12'h010, TAG_READ}, '0);
        push_exp(1, 64'h5000, 8'h77, {12'h010, TAG_READ});
        serve_mem(1, 2, 8'h77, g, ma, mt, md);
        chk("slow_grant", g, 1);
        set_req(0, 64'h6000, {12'h018, TAG_READ}, '0);
        a0 = ack_cnt[0];
        repeat (10) begin
            tick();
            chk("slow_respcyc", up_respcyc, 2'b10);
            chk("slow_resp", up_resp, exp_data(64'h5000, 8'h77));
            chk("slow_no_grant", mem_reqcyc, 0);
        end
        chk("slow_no_ack", ack_cnt[0] - a0, 0);
        push_exp(0, 64'h6000, 8'h99, {12'h018, TAG_READ});
        up_respack = 2'b11;
        serve_mem(0, 1, 8'h99, g, ma, mt, md);
        chk("slow_next_grant", g, 0);
        chk("slow_next_mem_req", ma, 64'h6000);
        repeat (3) tick();

        // Reset while the memory response is outstanding
        set_req(0, 64'h7000, {12'h020, TAG_READ}, '0);
        n = 0;
        while (!mem_reqcyc && n < 20) begin
            tick();
            n++;
        end
        chk("rw_reqcyc", mem_reqcyc, 1);
        up_reqcyc  = '0;
        mem_reqack = 1'b1;
        tick();
        mem_reqack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_up_reqack", up_reqack, 0);
        chk("rw_up_respcyc", up_respcyc, 0);
        chk("rw_mem_reqcyc", mem_reqcyc, 0);
        chk("rw_mem_req", mem_req, 0);
        chk("rw_mem_reqtag", mem_reqtag, 0);
        chk("rw_mem_reqdata", mem_reqdata, 0);
        chk("rw_up_resp", up_resp, 0);
        chk("rw_up_resptag", up_resptag, 0);
        mem_resp    = {64{8'hDE}};
        mem_resptag = {12'h020, TAG_READ};
        mem_respcyc = 1'b1;
        repeat (4) begin
            tick();
            chk("late_respack", mem_respack, 0);
            chk("late_respcyc", up_respcyc, 0);
            chk("late_no_req", mem_reqcyc, 0);
        end
        mem_respcyc = 1'b0;
        mem_resp    = '0;
        mem_resptag = '0;
        repeat (2) tick();

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_mem_arbiter.md
Name: mod_mem_arbiter

Overview:
- Shares the single memory-side bus between the L1 instruction cache (requester 0) and the L1 data cache (requester 1).
- Each requester sees a CacheArbiterBus-style handshake: reqcyc/reqack for requests, respcyc/respack for responses.
- The block serialises traffic with one outstanding memory transaction at a time and routes each response back to the requester that issued it.
- Placement: between the L1 caches and the memory/system-bus port.

Parameters:
- ADDRW, 64, request address width.
- TAGW, 13, reqtag/resptag width; bit 0 is the READ/WRITE flag, the upper bits are type and id.
- BLKW, 512, cache block data width (64-byte block).
- NREQ, 2, number of requesters; the design is fixed at 2, index 0 = icache, 1 = dcache.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- up_req  in  [NREQ][ADDRW]  per-requester address.
- up_reqtag  in  [NREQ][TAGW]  per-requester tag.
- up_reqdata  in  [NREQ][BLKW]  write block data.
- up_reqcyc  in  [NREQ]  request valid, held until reqack.
- up_reqack  out  [NREQ]  one-cycle accept pulse.
- up_resp  out  [BLKW]  response data, shared by both requesters.
- up_resptag  out  [TAGW]  response tag.
- up_respcyc  out  [NREQ]  response valid to the owning requester.
- up_respack  in  [NREQ]  response consumed.
- mem_req  out  ADDRW  memory address.
- mem_reqtag  out  TAGW  memory tag.
- mem_reqdata  out  BLKW  memory write data.
- mem_reqcyc  out  1  memory request valid.
- mem_reqack  in  1  memory accepted the request.
- mem_resp  in  BLKW  memory response data.
- mem_resptag  in  TAGW  memory response tag.
- mem_respcyc  in  1  memory response valid.
- mem_respack  out  1  response accepted.

Behaviour:
- Reset: state=IDLE, last_grant=1 (so the icache wins the first tie), and all outputs 0: up_reqack, up_respcyc, mem_reqcyc, mem_req/tag/data, up_resp/tag.
- Reset asserted mid-operation aborts any in-flight transaction without a response. mem_reqcyc is 0 after the reset edge.
- IDLE:
  - If any up_reqcyc is high, pick grant g (round-robin: if both request, g = ~last_grant).
  - Latch up_req[g]/reqtag[g]/reqdata[g] into mem_req/mem_reqtag/mem_reqdata.
  - up_reqack[g]<=1 for exactly one cycle; mem_reqcyc<=1; go to ISSUE.
  - The request therefore appears on the memory bus 1 cycle after sampling.
- ISSUE: hold mem_reqcyc and the latched fields stable. On mem_reqack=1, mem_reqcyc<=0 and go to WAIT. mem_reqack in the same cycle that mem_reqcyc first rises is valid.
- WAIT: mem_respack = mem_respcyc (combinational, only in WAIT). On mem_respcyc:
  - up_resp<=mem_resp, up_resptag<=mem_resptag.
  - up_respcyc[g]<=1; go to RETURN.
- WAIT applies to both reads and writes: a write returns a response with no meaningful data.
- RETURN: hold up_respcyc[g] and data until up_respack[g]=1. Then up_respcyc<=0, last_grant<=g, go to IDLE.
- The next grant can be sampled in the cycle after IDLE is re-entered, so there is a minimum 1-cycle bubble between transactions.
- Back-to-back throughput: no new request is accepted before RETURN completes.
- Outside WAIT, mem_respack=0 and mem_respcyc is ignored and not forwarded.
- up_respcyc[~g] and up_reqack[~g] are never asserted while g is owned.
- A requester that drops reqcyc before ack is not required to be handled; such a request is simply not granted.

Optional Feature:
- ARB_DCACHE_PRIO_EN defined: fixed priority. The dcache (index 1) always wins when both requesters are high, and last_grant is unused.
- ARB_DCACHE_PRIO_EN undefined: round-robin as described in Behaviour.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, ISSUE, WAIT, RETURN}, parameters ADDRW/TAGW/BLKW, and named tag-bit constants (READ=1, WRITE=0 at bit 0).
- One natural sub-module: mod_rr_picker, a 2-input grant selector with a last_grant input that honours ARB_DCACHE_PRIO_EN. Everything else stays in mod_mem_arbiter.

Test Plan:
- Single icache read:
  - Stimulus: up_reqcyc[0]=1, up_req[0]=0x1000, tag=0x001. Memory acks after 2 cycles and responds with 0xAA.. after 5.
  - Expect: up_reqack[0] pulses once, mem_req=0x1000, up_respcyc[0]=1 with resp=0xAA.., and up_respcyc[1] stays 0.
- Simultaneous requests:
  - Stimulus: both reqcyc held high for 4 transactions, with addresses 0x2000 (icache) and 0x3000 (dcache).
  - Expect: grants ordered 0,1,0,1. With ARB_DCACHE_PRIO_EN defined, both dcache transactions complete first.
- Dcache write:
  - Stimulus: up_reqtag[1] bit0=WRITE, data=0x55.., addr=0x4040.
  - Expect: mem_reqdata=0x55.. stable until mem_reqack, and a response is routed to requester 1 only.
- Slow respack:
  - Stimulus: requester holds up_respack=0 for 10 cycles after respcyc.
  - Expect: up_respcyc and up_resp stay stable, and no new grant is given despite a pending up_reqcyc[0].
- Reset during WAIT:
  - Stimulus: reset for 1 cycle while the memory response is outstanding, then a late mem_respcyc arrives.
  - Expect: all outputs 0 and state IDLE. The late mem_respcyc is not acked and not forwarded.
- Spurious response:
  - Stimulus: mem_respcyc=1 while IDLE.
  - Expect: mem_respack=0 and no up_respcyc.
